// File: rtl/song_pkg.sv
// ----------------------------------------------------------------------------
// song_pkg
// Shared definitions for the polyphonic song reader:
//   - 16-bit song entry layout (advance flag, note, duration, reserved bits)
//   - END_MARKER, the all-zero entry that terminates a ROM song
//   - sequencer FSM state encoding
//   - voice_width(), the width of a voice index for a given voice count
// ----------------------------------------------------------------------------
package song_pkg;

    localparam int ENTRY_W      = 16;
    localparam int ADV_BIT      = 15;  // 1 = time advance, 0 = note event
    localparam int NOTE_LSB     = 9;   // note field [14:9]
    localparam int NOTE_FIELD_W = 6;
    localparam int DUR_LSB      = 3;   // duration field [8:3]
    localparam int DUR_FIELD_W  = 6;   // bits [2:0] are reserved and ignored

    localparam logic [ENTRY_W-1:0] END_MARKER = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_WAIT_ADV,
        S_DONE
    } state_e;

    // A single voice still needs a one-bit index signal.
    function automatic int voice_width(input int num_voices);
        return (num_voices > 1) ? $clog2(num_voices) : 1;
    endfunction

endpackage

// File: rtl/song_reader_poly_if.sv
// ----------------------------------------------------------------------------
// song_reader_poly_if
// Note-event bus from the song reader to the note-player bank.
//   note_out      note of the current event
//   duration_out  duration of the current event
//   voice_out     voice slot the event is meant for
//   load_new_note one-cycle strobe: the three fields above are a new event
//   song_done     one-cycle pulse at the end of the song
// modport master: the song reader (drives everything)
// modport slave : the note-player bank (observes everything)
// ----------------------------------------------------------------------------
interface song_reader_poly_if
    import song_pkg::*;
#(
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int NUM_VOICES = 3
) ();

    localparam int VOICE_W = voice_width(NUM_VOICES);

    logic [NOTE_W-1:0]  note_out;
    logic [DUR_W-1:0]   duration_out;
    logic [VOICE_W-1:0] voice_out;
    logic               load_new_note;
    logic               song_done;

    modport master (
        output note_out,
        output duration_out,
        output voice_out,
        output load_new_note,
        output song_done
    );

    modport slave (
        input note_out,
        input duration_out,
        input voice_out,
        input load_new_note,
        input song_done
    );

endinterface

// File: rtl/song_ram.sv
// ----------------------------------------------------------------------------
// song_ram
// Record RAM: 2^ADDR_W x DATA_W, synchronous write, registered read.
//   clk     system clock
//   we      write strobe;  waddr / wdata write address and data
//   re      read enable;   raddr read address
//   rdata   read data, valid the cycle after re; held while re is low
// ----------------------------------------------------------------------------
module song_ram #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array and its read register carry no reset, so the recording
    // survives a reset of the sequencer and the block maps onto block RAM.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, whatever order the statements are written in.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // Holding the read register while re is low keeps a paused read alive.
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/song_reader_poly.sv
// ----------------------------------------------------------------------------
// song_reader_poly
// Sequences 16-bit song entries from the internal record RAM (song all-ones)
// or the external song ROM (any other song) and emits voice-tagged note
// events for a bank of NUM_VOICES note players, paced by the beat tick.
//   clk, reset        system clock, synchronous active-high reset
//   beat              one-cycle beat tick
//   play              high = run, low = pause (from DONE: return to IDLE)
//   loop              wrap to entry 0 at the end of the song
//   song              song select, sampled when playback starts
//   write_enable / write_address / write_payload   record RAM write port
//   done_recording    pulse: song length = last written address + 1
//   rom_addr          registered ROM address {song, step}
//   rom_data          ROM data, valid one cycle after rom_addr
//   evt               note-event bus (master side)
// ----------------------------------------------------------------------------
module song_reader_poly
    import song_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int SONG_BITS  = 2,
    parameter int STEP_W     = 5,
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        beat,
    input  logic                        play,
    input  logic                        loop,
    input  logic [SONG_BITS-1:0]        song,
    input  logic                        write_enable,
    input  logic [ADDR_W-1:0]           write_address,
    input  logic [ENTRY_W-1:0]          write_payload,
    input  logic                        done_recording,
    output logic [SONG_BITS+STEP_W-1:0] rom_addr,
    input  logic [ENTRY_W-1:0]          rom_data,
    song_reader_poly_if.master          evt
);

    localparam int VOICE_W = voice_width(NUM_VOICES);
    localparam int LEN_W   = ADDR_W + 1;  // a full RAM holds 2^ADDR_W entries
    // One spare bit lets the pointer step past the last RAM/ROM entry.
    localparam int PTR_W   = ((ADDR_W > STEP_W) ? ADDR_W : STEP_W) + 1;

    // ---------------------------------------------------------------- state
    state_e                      state_q,     state_d;
    logic [SONG_BITS-1:0]        song_sel_q,  song_sel_d;
    logic [PTR_W-1:0]            ptr_q,       ptr_d;
    logic [VOICE_W-1:0]          voice_q,     voice_d;
    logic [DUR_W-1:0]            beat_cnt_q,  beat_cnt_d;
    logic [LEN_W-1:0]            ram_len_q,   ram_len_d;
    logic [ADDR_W-1:0]           last_wr_q,   last_wr_d;
    logic                        wr_seen_q,   wr_seen_d;
    logic                        end_seen_q,  end_seen_d;
    logic [SONG_BITS+STEP_W-1:0] rom_addr_q,  rom_addr_d;
    logic [NOTE_W-1:0]           note_q,      note_d;
    logic [DUR_W-1:0]            dur_q,       dur_d;
    logic [VOICE_W-1:0]          voice_out_q, voice_out_d;
    logic                        load_q,      load_d;
    logic                        done_q,      done_d;

    logic                        ram_rd_en;
    logic [ENTRY_W-1:0]          ram_rdata;
    logic                        ram_sel;
    logic                        at_end;
    logic [ENTRY_W-1:0]          entry;

    // ------------------------------------------------------------ record RAM
    song_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (write_enable),
        .waddr (write_address),
        .wdata (write_payload),
        .re    (ram_rd_en),
        .raddr (ptr_q[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    assign ram_sel = (song_sel_q == '1);
    assign entry   = ram_sel ? ram_rdata : rom_data;

    // RAM songs end at the recorded length; ROM songs end after an END_MARKER
    // entry. Both also end once the pointer runs off the end of the store.
    always_comb begin
        if (ram_sel) begin
            at_end = (ptr_q == PTR_W'(ram_len_q)) || ((ptr_q >> ADDR_W) != '0);
        end else begin
            at_end = end_seen_q || ((ptr_q >> STEP_W) != '0);
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        song_sel_d  = song_sel_q;
        ptr_d       = ptr_q;
        voice_d     = voice_q;
        beat_cnt_d  = beat_cnt_q;
        ram_len_d   = ram_len_q;
        last_wr_d   = last_wr_q;
        wr_seen_d   = wr_seen_q;
        end_seen_d  = end_seen_q;
        rom_addr_d  = rom_addr_q;
        note_d      = note_q;
        dur_d       = dur_q;
        voice_out_d = voice_out_q;
        load_d      = 1'b0;
        done_d      = 1'b0;
        ram_rd_en   = 1'b0;

        // Recording bookkeeping runs in every state, playback included.
        if (write_enable) begin
            last_wr_d = write_address;
            wr_seen_d = 1'b1;
        end
        if (done_recording && wr_seen_q) begin
            ram_len_d = {1'b0, last_wr_q} + LEN_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (play) begin
                    song_sel_d = song;
                    ptr_d      = '0;
                    voice_d    = '0;
                    end_seen_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                if (play) begin
                    if (at_end) begin
                        done_d     = 1'b1;
                        end_seen_d = 1'b0;
                        if (loop) begin
                            ptr_d   = '0;
                            voice_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        ram_rd_en = ram_sel;
                        if (!ram_sel) begin
                            rom_addr_d = {song_sel_q, ptr_q[STEP_W-1:0]};
                        end
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (play) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (play) begin
                    if (!ram_sel && (entry == END_MARKER)) begin
                        // Not an event: flag it so the next FETCH ends the song.
                        end_seen_d = 1'b1;
                        state_d    = S_FETCH;
                    end else if (entry[ADV_BIT]) begin
                        voice_d = '0;
                        ptr_d   = ptr_q + PTR_W'(1);
                        if (entry[DUR_LSB +: DUR_W] == '0) begin
                            state_d = S_FETCH;
                        end else begin
                            beat_cnt_d = entry[DUR_LSB +: DUR_W];
                            state_d    = S_WAIT_ADV;
                        end
                    end else begin
                        note_d      = entry[NOTE_LSB +: NOTE_W];
                        dur_d       = entry[DUR_LSB +: DUR_W];
                        voice_out_d = voice_q;
                        load_d      = 1'b1;
                        // Chords wider than the bank wrap back onto slot 0.
                        voice_d     = (voice_q == VOICE_W'(NUM_VOICES - 1))
                                      ? '0 : voice_q + VOICE_W'(1);
                        ptr_d       = ptr_q + PTR_W'(1);
                        state_d     = S_FETCH;
                    end
                end
            end

            S_WAIT_ADV: begin
                if (play && beat) begin
                    beat_cnt_d = beat_cnt_q - DUR_W'(1);
                    if (beat_cnt_q == DUR_W'(1)) begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                if (!play) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            song_sel_q  <= '0;
            ptr_q       <= '0;
            voice_q     <= '0;
            beat_cnt_q  <= '0;
            ram_len_q   <= '0;
            last_wr_q   <= '0;
            wr_seen_q   <= 1'b0;
            end_seen_q  <= 1'b0;
            rom_addr_q  <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            voice_out_q <= '0;
            load_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            song_sel_q  <= song_sel_d;
            ptr_q       <= ptr_d;
            voice_q     <= voice_d;
            beat_cnt_q  <= beat_cnt_d;
            ram_len_q   <= ram_len_d;
            last_wr_q   <= last_wr_d;
            wr_seen_q   <= wr_seen_d;
            end_seen_q  <= end_seen_d;
            rom_addr_q  <= rom_addr_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            voice_out_q <= voice_out_d;
            load_q      <= load_d;
            done_q      <= done_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign rom_addr          = rom_addr_q;
    assign evt.note_out      = note_q;
    assign evt.duration_out  = dur_q;
    assign evt.voice_out     = voice_out_q;
    assign evt.load_new_note = load_q;
    assign evt.song_done     = done_q;

endmodule

// File: tb/tb_song_reader_poly.sv
// ----------------------------------------------------------------------------
// tb_song_reader_poly
// Self-checking bench for song_reader_poly. Expected events are queued as
// stimulus is applied; a negedge monitor pops and compares each strobe and
// song_done pulse. A beat generator ticks every BEAT_DIV cycles, re-phased on
// each note strobe so beat gaps between strobes are exact.
// ----------------------------------------------------------------------------
module tb_song_reader_poly;
    import song_pkg::*;

    localparam int ADDR_W     = 7;
    localparam int SONG_BITS  = 2;
    localparam int STEP_W     = 5;
    localparam int NUM_VOICES = 3;
    localparam int NOTE_W     = 6;
    localparam int DUR_W      = 6;
    localparam int BEAT_DIV   = 8;
    localparam int BUDGET     = 3000;

    typedef struct {
        bit is_done;
        int note;
        int dur;
        int voice;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        beat;
    logic                        play;
    logic                        loop;
    logic [SONG_BITS-1:0]        song;
    logic                        write_enable;
    logic [ADDR_W-1:0]           write_address;
    logic [15:0]                 write_payload;
    logic                        done_recording;
    logic [SONG_BITS+STEP_W-1:0] rom_addr;
    logic [15:0]                 rom_data;

    logic [15:0] rom [128];
    logic [15:0] rec [5];
    exp_t        sb_q [$];
    exp_t        mon_e;

    int checks      = 0;
    int errors      = 0;
    int strobe_cnt  = 0;
    int done_cnt    = 0;
    int beats_since = 0;
    int last_gap    = 0;
    int beat_div    = 0;

    song_reader_poly_if #(
        .NOTE_W     (NOTE_W),
        .DUR_W      (DUR_W),
        .NUM_VOICES (NUM_VOICES)
    ) evt_if ();

    song_reader_poly #(
        .ADDR_W     (ADDR_W),
        .SONG_BITS  (SONG_BITS),
        .STEP_W     (STEP_W),
        .NUM_VOICES (NUM_VOICES),
        .NOTE_W     (NOTE_W),
        .DUR_W      (DUR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .beat           (beat),
        .play           (play),
        .loop           (loop),
        .song           (song),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_payload  (write_payload),
        .done_recording (done_recording),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .evt            (evt_if)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ent(input logic adv, input int note, input int dur,
                                        input logic [2:0] rsv);
        return {adv, note[5:0], dur[5:0], rsv};
    endfunction

    task automatic push_note(input int note, input int dur, input int voice);
        exp_t e;
        e.is_done = 1'b0;
        e.note    = note;
        e.dur     = dur;
        e.voice   = voice;
        sb_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.note    = 0;
        e.dur     = 0;
        e.voice   = 0;
        sb_q.push_back(e);
    endtask

    // The recorded song: note 23 and 24 as a chord, 10-beat rest, then 22.
    task automatic push_ram_pass();
        push_note(23, 5, 0);
        push_note(24, 5, 1);
        push_note(22, 5, 0);
        push_done();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_note"},  32'(evt_if.note_out), 0);
        check({tag, "_dur"},   32'(evt_if.duration_out), 0);
        check({tag, "_voice"}, 32'(evt_if.voice_out), 0);
        check({tag, "_load"},  32'(evt_if.load_new_note), 0);
        check({tag, "_done"},  32'(evt_if.song_done), 0);
        check({tag, "_rom"},   32'(rom_addr), 0);
    endtask

    task automatic write_ram(input int addr, input logic [15:0] data);
        @(negedge clk);
        write_enable  = 1'b1;
        write_address = addr[ADDR_W-1:0];
        write_payload = data;
        @(negedge clk);
        write_enable  = 1'b0;
    endtask

    task automatic pulse_done_recording();
        @(negedge clk);
        done_recording = 1'b1;
        @(negedge clk);
        done_recording = 1'b0;
    endtask

    task automatic wait_dones(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_strobes(input int target, input string tag);
        int n = 0;
        while (strobe_cnt < target && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(strobe_cnt >= target), 1);
    endtask

    task automatic wait_beats(input int target, input string tag);
        int n = 0;
        while (beats_since < target && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(beats_since >= target), 1);
    endtask

    // From DONE, dropping play returns the reader to IDLE.
    task automatic stop_play();
        @(negedge clk);
        play = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // -------------------------------------------------------- ROM and beat
    initial begin
        rom_data = '0;
        forever begin
            @(posedge clk);
            rom_data <= rom[rom_addr];
        end
    end

    initial begin
        beat = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (evt_if.load_new_note) begin
                beat_div = 0;
                beat     = 1'b0;
            end else if (beat_div == BEAT_DIV - 1) begin
                beat_div = 0;
                beat     = 1'b1;
            end else begin
                beat_div++;
                beat     = 1'b0;
            end
        end
    end

    // --------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (beat) begin
            beats_since++;
        end
        if (evt_if.load_new_note || evt_if.song_done) begin
            if (evt_if.load_new_note) begin
                strobe_cnt++;
                last_gap    = beats_since;
                beats_since = 0;
            end
            if (evt_if.song_done) begin
                done_cnt++;
            end
            check("sb_has_entry", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("evt_kind", 32'(evt_if.song_done), 32'(mon_e.is_done));
                if (!mon_e.is_done) begin
                    check("evt_note",  32'(evt_if.note_out),     mon_e.note);
                    check("evt_dur",   32'(evt_if.duration_out), mon_e.dur);
                    check("evt_voice", 32'(evt_if.voice_out),    mon_e.voice);
                end
            end
        end
    end

    // ------------------------------------------------------------------ main
    initial begin
        int d0;
        int s0;
        int sp;
        int n;

        reset          = 1'b1;
        play           = 1'b0;
        loop           = 1'b0;
        song           = '0;
        write_enable   = 1'b0;
        write_address  = '0;
        write_payload  = '0;
        done_recording = 1'b0;

        rec[0] = ent(1'b1, 0, 0, 3'b000);
        rec[1] = ent(1'b0, 23, 5, 3'b000);
        rec[2] = ent(1'b0, 24, 5, 3'b111);   // reserved bits must be ignored
        rec[3] = ent(1'b1, 0, 10, 3'b000);
        rec[4] = ent(1'b0, 22, 5, 3'b000);

        for (int i = 0; i < 128; i++) begin
            rom[i] = ent(1'b0, 40 + (i % 8), 2, 3'b000);
        end
        rom[32] = ent(1'b0, 10, 1, 3'b000);
        rom[33] = ent(1'b0, 11, 2, 3'b000);
        rom[34] = ent(1'b0, 12, 3, 3'b000);
        rom[35] = ent(1'b0, 13, 4, 3'b000);
        rom[36] = 16'h0000;

        // Reset for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;

        // Record the RAM song and play it once.
        for (int i = 0; i < 5; i++) begin
            write_ram(i, rec[i]);
        end
        pulse_done_recording();
        push_ram_pass();
        d0 = done_cnt;
        s0 = strobe_cnt;
        @(negedge clk);
        song = 2'b11;
        play = 1'b1;
        wait_dones(d0 + 1, "rec_done_timeout");
        check("rec_gap_beats", last_gap, 10);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("rec_strobes", strobe_cnt - s0, 3);
        check("rec_single_done", done_cnt - d0, 1);
        check("done_hold_note", 32'(evt_if.note_out), 22);
        check("done_hold_voice", 32'(evt_if.voice_out), 0);
        check("rec_sb_drained", sb_q.size(), 0);
        stop_play();

        // Loop: three full passes, then a fourth that ends in DONE.
        loop = 1'b1;
        repeat (4) push_ram_pass();
        d0 = done_cnt;
        s0 = strobe_cnt;
        @(negedge clk);
        play = 1'b1;
        wait_dones(d0 + 3, "loop_pass3_timeout");
        @(negedge clk);
        loop = 1'b0;
        wait_dones(d0 + 4, "loop_end_timeout");
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("loop_strobes", strobe_cnt - s0, 12);
        check("loop_dones", done_cnt - d0, 4);
        check("loop_sb_drained", sb_q.size(), 0);
        stop_play();

        // Pause for 7 beats inside the 10-beat rest.
        push_ram_pass();
        d0 = done_cnt;
        s0 = strobe_cnt;
        @(negedge clk);
        play = 1'b1;
        wait_strobes(s0 + 2, "pause_chord_timeout");
        wait_beats(3, "pause_start_timeout");
        @(negedge clk);
        play = 1'b0;
        sp = strobe_cnt;
        wait_beats(10, "pause_end_timeout");
        @(negedge clk);
        check("pause_no_strobe", strobe_cnt - sp, 0);
        play = 1'b1;
        wait_dones(d0 + 1, "pause_done_timeout");
        check("pause_gap_beats", last_gap, 17);
        check("pause_sb_drained", sb_q.size(), 0);
        stop_play();

        // Reset in the middle of the rest.
        push_ram_pass();
        s0 = strobe_cnt;
        @(negedge clk);
        play = 1'b1;
        wait_strobes(s0 + 2, "midrst_chord_timeout");
        wait_beats(2, "midrst_beats_timeout");
        @(negedge clk);
        reset = 1'b1;
        play  = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        check_zero_outputs("midrst");
        reset = 1'b0;

        // The recorded length is gone: playing the RAM ends at once.
        push_done();
        d0 = done_cnt;
        s0 = strobe_cnt;
        @(negedge clk);
        play = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        check("empty_done_seen", 32'(done_cnt - d0), 1);
        check("empty_latency_le3", 32'(n <= 3), 1);
        check("empty_no_strobe", strobe_cnt - s0, 0);
        stop_play();

        // Rewrite only the last entry; entries 0-3 must still be in the RAM.
        write_ram(4, rec[4]);
        pulse_done_recording();
        push_ram_pass();
        d0 = done_cnt;
        s0 = strobe_cnt;
        @(negedge clk);
        play = 1'b1;
        wait_dones(d0 + 1, "replay_done_timeout");
        check("replay_strobes", strobe_cnt - s0, 3);
        check("replay_sb_drained", sb_q.size(), 0);
        stop_play();

        // ROM song 1: four notes, voice wraps 0,1,2,0, then the end marker.
        push_note(10, 1, 0);
        push_note(11, 2, 1);
        push_note(12, 3, 2);
        push_note(13, 4, 0);
        push_done();
        d0 = done_cnt;
        s0 = strobe_cnt;
        @(negedge clk);
        song = 2'b01;
        play = 1'b1;
        wait_strobes(s0 + 1, "rom_first_timeout");
        @(negedge clk);
        song = 2'b10;   // ignored until the next IDLE
        wait_dones(d0 + 1, "rom_done_timeout");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rom_strobes", strobe_cnt - s0, 4);
        check("rom_addr_last", 32'(rom_addr), 36);
        check("rom_hold_note", 32'(evt_if.note_out), 13);
        stop_play();

        check("final_sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
